bp_be_instr_encoder: RTL and testbench



---
 rtl/bp_be_instr_encoder.sv | 191 +++++++++++++++++++
 tb/tb_bp_be_instr_encoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_instr_encoder
// Purpose  : Packs abstract RV64 instruction descriptors (R, R4, I, S, B, U,
//            J) into 32-bit instruction words, range-checks the immediate,
//            and queues the results in an elastic valid/ready output FIFO.
//            Counts every instruction the consumer takes.
// Revision : 1.0 - initial release
// ============================================================================
module bp_be_instr_encoder #(
    parameter int els_p         = 2,
    parameter int count_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [2:0]               fmt_i,
    input  logic [6:0]               opcode_i,
    input  logic [2:0]               funct3_i,
    input  logic [6:0]               funct7_i,
    input  logic [4:0]               rd_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    input  logic [4:0]               rs3_i,
    input  logic [63:0]              imm_i,
    output logic                     v_o,
    output logic [31:0]              instr_o,
    output logic                     err_o,
    input  logic                     yumi_i,
    output logic [count_width_p-1:0] count_o
);

    // Pointer is at least one bit wide so a single-entry FIFO still elaborates.
    localparam int c_ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int c_occ_w = $clog2(els_p + 1);

    localparam logic [c_occ_w-1:0]       c_els       = c_occ_w'(els_p);
    localparam logic [c_occ_w-1:0]       c_occ_one   = c_occ_w'(1);
    localparam logic [c_ptr_w-1:0]       c_last_ptr  = c_ptr_w'(els_p - 1);
    localparam logic [c_ptr_w-1:0]       c_ptr_one   = c_ptr_w'(1);
    localparam logic [count_width_p-1:0] c_cnt_one   = count_width_p'(1);

    localparam logic [2:0] c_fmt_r  = 3'd0;
    localparam logic [2:0] c_fmt_i  = 3'd1;
    localparam logic [2:0] c_fmt_s  = 3'd2;
    localparam logic [2:0] c_fmt_b  = 3'd3;
    localparam logic [2:0] c_fmt_u  = 3'd4;
    localparam logic [2:0] c_fmt_j  = 3'd5;
    localparam logic [2:0] c_fmt_r4 = 3'd6;

    // Legal immediate ranges, as signed 64-bit byte offsets.
    localparam logic signed [63:0] c_is_min = -64'sd2048;
    localparam logic signed [63:0] c_is_max =  64'sd2047;
    localparam logic signed [63:0] c_b_min  = -64'sd4096;
    localparam logic signed [63:0] c_b_max  =  64'sd4094;
    localparam logic signed [63:0] c_j_min  = -64'sd1048576;
    localparam logic signed [63:0] c_j_max  =  64'sd1048574;
    localparam logic signed [63:0] c_u_min  = -64'sd2147483648;
    localparam logic signed [63:0] c_u_max  =  64'sd2147479552;

    logic signed [63:0] w_imm;
    logic [31:0]        w_instr;
    logic               w_err;
    logic               w_push;
    logic               w_pop;
    logic               w_v;
    logic [32:0]        w_head;

    logic [c_occ_w-1:0]       occ_q, occ_d;
    logic [c_ptr_w-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]       rd_ptr_q, rd_ptr_d;
    logic                     ready_q, ready_d;
    logic [count_width_p-1:0] count_q, count_d;
    logic [32:0]              mem_q [els_p];
    logic [32:0]              mem_d [els_p];

    assign w_imm = $signed(imm_i);

    // Encode the incoming descriptor and flag immediates that do not fit.
    always_comb begin
        w_instr = 32'h0;
        w_err   = 1'b0;
        case (fmt_i)
            c_fmt_r: begin
                w_instr = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            c_fmt_r4: begin
                w_instr = {rs3_i, funct7_i[1:0], rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            c_fmt_i: begin
                w_instr = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                w_err   = (w_imm < c_is_min) || (w_imm > c_is_max);
            end
            c_fmt_s: begin
                w_instr = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                w_err   = (w_imm < c_is_min) || (w_imm > c_is_max);
            end
            c_fmt_b: begin
                w_instr = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
                w_err   = (w_imm < c_b_min) || (w_imm > c_b_max) || imm_i[0];
            end
            c_fmt_u: begin
                w_instr = {imm_i[31:12], rd_i, opcode_i};
                w_err   = (w_imm < c_u_min) || (w_imm > c_u_max) || (imm_i[11:0] != 12'h0);
            end
            c_fmt_j: begin
                w_instr = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                w_err   = (w_imm < c_j_min) || (w_imm > c_j_max) || imm_i[0];
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
        // A failed entry carries the all-zero canonical illegal instruction.
        if (w_err) begin
            w_instr = 32'h0;
        end
    end

    assign w_v    = (occ_q != '0);
    assign w_push = v_i & ready_q;
    // A yumi on an empty FIFO is ignored so state cannot be corrupted.
    assign w_pop  = yumi_i & w_v;
    assign w_head = mem_q[rd_ptr_q];

    // Next-state for occupancy, pointers, registered ready and pop counter.
    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push && !w_pop) begin
            occ_d = occ_q + c_occ_one;
        end else if (!w_push && w_pop) begin
            occ_d = occ_q - c_occ_one;
        end
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + c_ptr_one;
            count_d  = count_q + c_cnt_one;
        end
        // Ready follows next-cycle occupancy only, never v_i combinationally.
        ready_d = (occ_d < c_els);
    end

    // Write the encoded entry into the slot at the write pointer.
    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {w_err, w_instr};
        end
    end

    // Control state; asynchronous reset drops every queued entry at once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign ready_o = ready_q;
    assign v_o     = w_v;
    assign instr_o = w_v ? w_head[31:0] : 32'h0;
    assign err_o   = w_v & w_head[32];
    assign count_o = count_q;

    a_yumi_only_when_valid : assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> w_v
    );

endmodule
`default_nettype wire

// File: tb/tb_bp_be_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_instr_encoder
// Purpose  : Self-checking bench for bp_be_instr_encoder: directed encodings,
//            error entries, backpressure, reset mid-stream and random traffic
//            against an arithmetic reference encoder and a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bp_be_instr_encoder;

    localparam int ELS = 2;

    typedef struct {
        logic [2:0] fmt;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
        longint     imm;
        logic [31:0] word;
        bit          err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic [2:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i, rs1_i, rs2_i, rs3_i;
    logic [63:0] imm_i;
    logic        v_o;
    logic [31:0] instr_o;
    logic        err_o;
    logic        yumi_i;
    logic [31:0] count_o;

    logic [32:0] exp_q[$];
    logic [31:0] exp_count;
    bit          exp_init;
    vec_t        cur;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bp_be_instr_encoder #(.els_p(ELS), .count_width_p(32)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .imm_i(imm_i),
        .v_o(v_o), .instr_o(instr_o), .err_o(err_o), .yumi_i(yumi_i), .count_o(count_o)
    );

    // Reference encoder: builds the word from shifted, masked field values.
    function automatic logic [32:0] ref_encode(input vec_t d);
        longint w, op, f3, f7, rd, rs1, rs2, rs3, imm;
        bit err;
        op = d.op; f3 = d.f3; f7 = d.f7; rd = d.rd;
        rs1 = d.rs1; rs2 = d.rs2; rs3 = d.rs3; imm = d.imm;
        w = 0; err = 0;
        case (d.fmt)
            3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd6: w = (rs3 << 27) | ((f7 & 3) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: begin
                err = (imm < -2048) || (imm > 2047);
                w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            end
            3'd2: begin
                err = (imm < -2048) || (imm > 2047);
                w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 'h1F) << 7) | op;
            end
            3'd3: begin
                err = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                  | (f3 << 12) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
            end
            3'd4: begin
                err = (imm < -64'sd2147483648) || (imm > 64'sd2147479552) || ((imm & 'hFFF) != 0);
                w = (imm & 'hFFFFF000) | (rd << 7) | op;
            end
            3'd5: begin
                err = (imm < -1048576) || (imm > 1048574) || ((imm & 1) != 0);
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | op;
            end
            default: err = 1;
        endcase
        if (err) w = 0;
        return {err, w[31:0]};
    endfunction

    task automatic set_desc(input vec_t d);
        cur      = d;
        fmt_i    = d.fmt;
        opcode_i = d.op;
        funct3_i = d.f3;
        funct7_i = d.f7;
        rd_i     = d.rd;
        rs1_i    = d.rs1;
        rs2_i    = d.rs2;
        rs3_i    = d.rs3;
        imm_i    = d.imm;
    endtask

    // One clock from negedge to negedge; updates the queue model at the edge.
    task automatic cycle(input bit v, input bit yumi, output bit accepted);
        logic [32:0] enc;
        bit do_pop;
        enc      = ref_encode(cur);
        do_pop   = yumi && (exp_q.size() > 0);
        accepted = v && exp_init && (exp_q.size() < ELS);
        v_i      = v;
        yumi_i   = do_pop;
        @(posedge clk);
        if (do_pop) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 1;
        end
        if (accepted) exp_q.push_back(enc);
        exp_init = 1;
        @(negedge clk);
        v_i    = 1'b0;
        yumi_i = 1'b0;
    endtask

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rs3, input longint imm,
                                input logic [31:0] word, input bit err);
        vec_t d;
        d.fmt = fmt; d.op = op; d.f3 = f3; d.f7 = f7; d.rd = rd; d.rs1 = rs1;
        d.rs2 = rs2; d.rs3 = rs3; d.imm = imm; d.word = word; d.err = err;
        return d;
    endfunction

    task automatic test_reset();
        bit acc;
        reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
        set_desc(mk(3'd0, 7'h0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 32'h0, 1'b0));
        exp_q.delete(); exp_count = '0; exp_init = 0;
        #1;
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b expected 0", v_o); end
        n_cmp++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr_o: got %h expected 0", instr_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err_o: got %b expected 0", err_o); end
        n_cmp++; if (count_o !== 32'h0) begin n_fail++; $display("FAIL reset_count_o: got %0d expected 0", count_o); end
        @(negedge clk);
        reset_n_i = 1'b1;
        cycle(1'b0, 1'b0, acc);
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after_release: got %b expected 1", ready_o); end
    endtask

    // Known-good words, error entries interleaved with valid neighbours,
    // streamed at one per cycle with the consumer taking every cycle.
    task automatic test_encodings();
        vec_t vs[14];
        bit acc;
        vs[0]  = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5,           32'h00500093, 1'b0);
        vs[1]  = mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 5'd0, 0,           32'h002081B3, 1'b0);
        vs[2]  = mk(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 5'd0, 8,           32'h0020A423, 1'b0);
        vs[3]  = mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 5'd0, -4,          32'hFE000EE3, 1'b0);
        vs[4]  = mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 5'd0, 'h12345000,  32'h123452B7, 1'b0);
        vs[5]  = mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5'd0, 2048,        32'h001000EF, 1'b0);
        vs[6]  = mk(3'd6, 7'h43, 3'd0, 7'd1, 5'd1, 5'd2, 5'd3, 5'd4, 0,           32'h223100C3, 1'b0);
        vs[7]  = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5'd0, 2048,        32'h0,        1'b1);
        vs[8]  = mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 5'd0, 0,           32'h002081B3, 1'b0);
        vs[9]  = mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 5'd0, 3,           32'h0,        1'b1);
        vs[10] = mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 5'd0, 'h12345000,  32'h123452B7, 1'b0);
        vs[11] = mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 5'd0, 'h1001,      32'h0,        1'b1);
        vs[12] = mk(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5'd0, 0,           32'h0,        1'b1);
        vs[13] = mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5'd0, 2048,        32'h001000EF, 1'b0);
        for (int i = 0; i <= 14; i++) begin
            if (i > 0) begin
                n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL enc_v_o[%0d]: got %b expected 1", i-1, v_o); end
                n_cmp++; if (instr_o !== vs[i-1].word) begin n_fail++; $display("FAIL enc_instr[%0d]: got %h expected %h", i-1, instr_o, vs[i-1].word); end
                n_cmp++; if (err_o !== vs[i-1].err) begin n_fail++; $display("FAIL enc_err[%0d]: got %b expected %b", i-1, err_o, vs[i-1].err); end
            end
            n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL enc_ready[%0d]: got %b expected 1", i, ready_o); end
            if (i < 14) begin
                set_desc(vs[i]);
                cycle(1'b1, 1'b1, acc);
            end else begin
                cycle(1'b0, 1'b1, acc);
            end
        end
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL enc_drained_v_o: got %b expected 0", v_o); end
        n_cmp++; if (count_o !== exp_count) begin n_fail++; $display("FAIL enc_count: got %0d expected %0d", count_o, exp_count); end
    endtask

    task automatic test_backpressure();
        vec_t d;
        bit acc;
        int k;
        int guard;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            d = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 5'd0, k + 1, 32'h0, 1'b0);
            set_desc(d);
            cycle(1'b1, 1'b0, acc);
            if (acc) k++;
            n_cmp++; if (ready_o !== (i == 0)) begin n_fail++; $display("FAIL bp_ready_after_push%0d: got %b expected %b", i, ready_o, i == 0); end
        end
        n_cmp++; if (k !== 2) begin n_fail++; $display("FAIL bp_model_accepts: got %0d expected 2", k); end
        n_cmp++; if (instr_o !== 32'h00100093) begin n_fail++; $display("FAIL bp_head_held: got %h expected 00100093", instr_o); end
        guard = 0;
        while ((k < 6 || exp_q.size() > 0) && guard < 30) begin
            guard++;
            n_cmp++; if (v_o !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL bp_v_o: got %b expected %b", v_o, exp_q.size() > 0); end
            n_cmp++; if (ready_o !== (exp_q.size() < ELS)) begin n_fail++; $display("FAIL bp_ready: got %b expected %b", ready_o, exp_q.size() < ELS); end
            n_cmp++; if (count_o !== exp_count) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", count_o, exp_count); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({err_o, instr_o} !== exp_q[0]) begin n_fail++; $display("FAIL bp_head: got %b/%h expected %b/%h", err_o, instr_o, exp_q[0][32], exp_q[0][31:0]); end
            end
            d = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'(k + 1), 5'd0, 5'd0, 5'd0, k + 1, 32'h0, 1'b0);
            set_desc(d);
            cycle(k < 6, 1'b1, acc);
            if (acc) k++;
        end
        n_cmp++; if (guard >= 30) begin n_fail++; $display("FAIL bp_timeout: got %0d cycles expected < 30", guard); end
        n_cmp++; if (count_o !== exp_count) begin n_fail++; $display("FAIL bp_final_count: got %0d expected %0d", count_o, exp_count); end
    endtask

    task automatic test_reset_midstream();
        bit acc;
        set_desc(mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 5'd0, 0, 32'h0, 1'b0));
        cycle(1'b1, 1'b0, acc);
        cycle(1'b1, 1'b0, acc);
        n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL mid_v_before: got %b expected 1", v_o); end
        n_cmp++; if (count_o !== exp_count) begin n_fail++; $display("FAIL mid_count_before: got %0d expected %0d", count_o, exp_count); end
        #2;
        reset_n_i = 1'b0;
        exp_q.delete(); exp_count = '0; exp_init = 0;
        #1;
        n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL mid_v_async: got %b expected 0", v_o); end
        n_cmp++; if (count_o !== 32'h0) begin n_fail++; $display("FAIL mid_count_async: got %0d expected 0", count_o); end
        n_cmp++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL mid_instr_async: got %h expected 0", instr_o); end
        @(posedge clk);
        @(negedge clk);
        reset_n_i = 1'b1;
        cycle(1'b0, 1'b0, acc);
        n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_ready_release: got %b expected 1", ready_o); end
        set_desc(mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 5'd0, 'h12345000, 32'h0, 1'b0));
        cycle(1'b1, 1'b0, acc);
        n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL mid_first_v: got %b expected 1", v_o); end
        n_cmp++; if (instr_o !== 32'h123452B7) begin n_fail++; $display("FAIL mid_first_instr: got %h expected 123452B7", instr_o); end
        cycle(1'b0, 1'b1, acc);
        n_cmp++; if (count_o !== 32'd1) begin n_fail++; $display("FAIL mid_count_after: got %0d expected 1", count_o); end
    endtask

    function automatic longint rand_imm();
        longint b[15];
        b = '{-64'sd2048, 64'sd2047, 64'sd2048, -64'sd2049, -64'sd4096, 64'sd4094, 64'sd4096, -64'sd4098,
              -64'sd1048576, 64'sd1048574, 64'sd1048576, -64'sd2147483648, 64'sd2147479552, 64'sd2147483648, 64'sd4095};
        case ($urandom_range(0, 4))
            0: return b[$urandom_range(0, 14)];
            1: return longint'($urandom_range(0, 12000)) - 6000;
            2: return {$urandom, $urandom};
            3: return longint'(int'($urandom & 32'hFFFFF000));
            default: return longint'($urandom_range(0, 4194303)) - 2097152;
        endcase
    endfunction

    task automatic test_random();
        vec_t d;
        bit acc;
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (v_o !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rnd_v_o@%0d: got %b expected %b", c, v_o, exp_q.size() > 0); end
            n_cmp++; if (ready_o !== (exp_q.size() < ELS)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, ready_o, exp_q.size() < ELS); end
            n_cmp++; if (count_o !== exp_count) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, count_o, exp_count); end
            if (exp_q.size() > 0) begin
                n_cmp++; if ({err_o, instr_o} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_head@%0d: got %b/%h expected %b/%h", c, err_o, instr_o, exp_q[0][32], exp_q[0][31:0]); end
            end
            d = mk(3'($urandom), 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 5'($urandom), rand_imm(), 32'h0, 1'b0);
            set_desc(d);
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, acc);
        end
    endtask

    initial begin
        test_reset();
        test_encodings();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
